// File: rtl/keypad_entry.sv
// 4x4 active-low keypad scanner with debounce, feeding a 4-digit BCD entry word.
// Digits shift in from the right; B backspaces, C clears, '#' commits.
module keypad_entry #(
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  col_in,
    output logic [3:0]  row_out,
    output logic [15:0] value,
    output logic [2:0]  digit_cnt,
    output logic        full,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        commit
);

    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
    localparam logic [3:0]  DB       = 4'(DEBOUNCE);
    localparam logic [3:0]  KEY_B    = 4'd7;
    localparam logic [3:0]  KEY_C    = 4'd11;
    localparam logic [3:0]  KEY_HASH = 4'd14;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE_ST,
        PRESSED
    } state_t;

    state_t      state_q;
    logic [3:0]  col_s1_q, col_s2_q;
    logic [3:0]  row_out_q;
    logic [1:0]  row_q;
    logic [15:0] div_q;
    logic [3:0]  match_q;
    logic [1:0]  cand_q;
    logic [15:0] value_q;
    logic [2:0]  digits_q;
    logic        key_valid_q;
    logic [3:0]  key_code_q;
    logic        commit_q;

    logic        sample_d;
    logic        any_low_d;
    logic [1:0]  low_col_d;
    logic        cand_ok_d;
    logic        accept_d;
    logic [3:0]  acc_code_d;
    logic        is_digit_d;
    logic [3:0]  digit_d;
    logic [15:0] value_d;
    logic [2:0]  digits_d;
    logic        commit_d;

    assign sample_d  = (div_q == DIV_LAST);
    assign cand_ok_d = any_low_d && (low_col_d == cand_q);

    always_comb begin
        low_col_d = '0;
        any_low_d = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!any_low_d && !col_s2_q[i]) begin
                low_col_d = 2'(i);
                any_low_d = 1'b1;
            end
        end
    end

    // With DEBOUNCE == 1 the first detection in SCAN is itself the accepting sample.
    always_comb begin
        accept_d   = 1'b0;
        acc_code_d = {row_q, cand_q};
        if (sample_d) begin
            case (state_q)
                SCAN: begin
                    if (any_low_d && DB == 4'd1) begin
                        accept_d   = 1'b1;
                        acc_code_d = {row_q, low_col_d};
                    end
                end
                DEBOUNCE_ST: accept_d = cand_ok_d && (match_q + 4'd1 == DB);
                default:     accept_d = 1'b0;
            endcase
        end
    end

    always_comb begin
        is_digit_d = 1'b1;
        case (acc_code_d)
            4'd0:    digit_d = 4'd1;
            4'd1:    digit_d = 4'd2;
            4'd2:    digit_d = 4'd3;
            4'd4:    digit_d = 4'd4;
            4'd5:    digit_d = 4'd5;
            4'd6:    digit_d = 4'd6;
            4'd8:    digit_d = 4'd7;
            4'd9:    digit_d = 4'd8;
            4'd10:   digit_d = 4'd9;
            4'd13:   digit_d = 4'd0;
            default: begin
                digit_d    = 4'd0;
                is_digit_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        value_d  = value_q;
        digits_d = digits_q;
        commit_d = 1'b0;
        if (is_digit_d) begin
            if (digits_q != 3'd4) begin
                value_d  = {value_q[11:0], digit_d};
                digits_d = digits_q + 3'd1;
            end
        end else if (acc_code_d == KEY_B) begin
            if (digits_q != 3'd0) begin
                value_d  = {4'h0, value_q[15:4]};
                digits_d = digits_q - 3'd1;
            end
        end else if (acc_code_d == KEY_C) begin
            value_d  = '0;
            digits_d = '0;
        end else if (acc_code_d == KEY_HASH) begin
            commit_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SCAN;
            col_s1_q    <= '1;
            col_s2_q    <= '1;
            row_out_q   <= 4'b1110;
            row_q       <= '0;
            div_q       <= '0;
            match_q     <= '0;
            cand_q      <= '0;
            value_q     <= '0;
            digits_q    <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            commit_q    <= 1'b0;
        end else begin
            col_s1_q    <= col_in;
            col_s2_q    <= col_s1_q;
            key_valid_q <= 1'b0;
            commit_q    <= 1'b0;
            if (accept_d) begin
                key_valid_q <= 1'b1;
                key_code_q  <= acc_code_d;
                value_q     <= value_d;
                digits_q    <= digits_d;
                commit_q    <= commit_d;
            end
            if (!sample_d) begin
                div_q <= div_q + 16'd1;
            end else begin
                div_q <= '0;
                case (state_q)
                    SCAN: begin
                        if (!any_low_d) begin
                            row_q     <= row_q + 2'd1;
                            row_out_q <= {row_out_q[2:0], row_out_q[3]};
                        end else if (accept_d) begin
                            cand_q  <= low_col_d;
                            match_q <= '0;
                            state_q <= PRESSED;
                        end else begin
                            cand_q  <= low_col_d;
                            match_q <= 4'd1;
                            state_q <= DEBOUNCE_ST;
                        end
                    end
                    DEBOUNCE_ST: begin
                        if (!cand_ok_d) begin
                            state_q   <= SCAN;
                            row_q     <= '0;
                            row_out_q <= 4'b1110;
                        end else if (accept_d) begin
                            match_q <= '0;
                            state_q <= PRESSED;
                        end else begin
                            match_q <= match_q + 4'd1;
                        end
                    end
                    default: begin
                        if (any_low_d) begin
                            match_q <= '0;
                        end else if (match_q + 4'd1 == DB) begin
                            match_q   <= '0;
                            state_q   <= SCAN;
                            row_q     <= '0;
                            row_out_q <= 4'b1110;
                        end else begin
                            match_q <= match_q + 4'd1;
                        end
                    end
                endcase
            end
        end
    end

    assign row_out   = row_out_q;
    assign value     = value_q;
    assign digit_cnt = digits_q;
    assign full      = (digits_q == 3'd4);
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign commit    = commit_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: keypad model driven from row_out, digit-list entry model,
// per-cycle invariant/state checks plus directed and random key presses.
module tb_keypad_entry;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DEBOUNCE = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  col_in;
    logic [3:0]  row_out;
    logic [15:0] value;
    logic [2:0]  digit_cnt;
    logic        full;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        commit;

    logic [15:0] keys = '0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          kv_cnt = 0;
    int          commit_cnt = 0;
    logic [3:0]  last_code = '0;
    bit          settled = 1'b0;
    int          mdl_q[$];
    logic        prev_kv = 1'b0;
    logic [3:0]  prev_row = 4'b1110;

    keypad_entry #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
        .clk       (clk),
        .rst       (rst),
        .col_in    (col_in),
        .row_out   (row_out),
        .value     (value),
        .digit_cnt (digit_cnt),
        .full      (full),
        .key_valid (key_valid),
        .key_code  (key_code),
        .commit    (commit)
    );

    always #5 clk = ~clk;

    // A pressed key pulls its column low only while its row is driven low.
    always_comb begin
        col_in = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int digit_of(input logic [3:0] code);
        case (code)
            4'd0: return 1;   4'd1: return 2;   4'd2: return 3;
            4'd4: return 4;   4'd5: return 5;   4'd6: return 6;
            4'd8: return 7;   4'd9: return 8;   4'd10: return 9;
            4'd13: return 0;
            default: return -1;
        endcase
    endfunction

    function automatic void mdl_apply(input logic [3:0] code);
        int d;
        d = digit_of(code);
        if (d >= 0) begin
            if (mdl_q.size() < 4) mdl_q.push_back(d);
        end else if (code == 4'd7) begin
            if (mdl_q.size() > 0) void'(mdl_q.pop_back());
        end else if (code == 4'd11) begin
            mdl_q.delete();
        end
    endfunction

    function automatic logic [15:0] mdl_value();
        int v;
        v = 0;
        for (int i = 0; i < mdl_q.size(); i++) v = v * 16 + mdl_q[i];
        return 16'(v);
    endfunction

    always @(negedge clk) begin
        chk("row_onehot", 32'($countones(~row_out)), 32'd1);
        if (row_out != prev_row)
            chk("row_step", 32'(row_out == {prev_row[2:0], prev_row[3]} || row_out == 4'b1110), 32'd1);
        prev_row = row_out;
        if (!rst) begin
            chk("commit_alone", 32'(commit & ~key_valid), 32'd0);
            chk("kv_width", 32'(prev_kv & key_valid), 32'd0);
            for (int i = 0; i < 4; i++)
                chk("bcd_nibble", 32'(value[4*i +: 4] <= 4'd9), 32'd1);
            if (key_valid) begin
                kv_cnt++;
                last_code = key_code;
                if (commit) commit_cnt++;
            end
            if (settled) begin
                chk("value", 32'(value), 32'(mdl_value()));
                chk("digit_cnt", 32'(digit_cnt), 32'(mdl_q.size()));
                chk("full", 32'(full), 32'(mdl_q.size() == 4));
                chk("kv_idle", 32'(key_valid), 32'd0);
            end
        end
        prev_kv = key_valid;
    end

    task automatic press(input logic [15:0] mask, input logic [3:0] code, input int hold);
        int kv0, cm0;
        settled = 1'b0;
        kv0 = kv_cnt;
        cm0 = commit_cnt;
        keys = mask;
        repeat (hold) @(negedge clk);
        keys = '0;
        repeat (60) @(negedge clk);
        chk("pulse_count", 32'(kv_cnt - kv0), 32'd1);
        chk("key_code", 32'(last_code), 32'(code));
        chk("commit_count", 32'(commit_cnt - cm0), (code == 4'd14) ? 32'd1 : 32'd0);
        mdl_apply(code);
        settled = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] exp_row;
        int kv0;
        logic [3:0] rc;

        // Reset values and idle row rotation.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_row", 32'(row_out), 32'hE);
        chk("rst_value", 32'(value), 32'h0);
        chk("rst_digit_cnt", 32'(digit_cnt), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_kv", 32'(key_valid), 32'd0);
        chk("rst_code", 32'(key_code), 32'd0);
        chk("rst_commit", 32'(commit), 32'd0);
        rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            exp_row = ~(4'b0001 << ((k / 4) % 4));
            chk("row_scan", 32'(row_out), 32'(exp_row));
        end

        // Reset right after the second matching sample aborts the press.
        rst = 1'b1;
        keys = 16'h0001;
        repeat (2) @(negedge clk);
        kv0 = kv_cnt;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        keys = '0;
        #1;
        chk("midrst_row", 32'(row_out), 32'hE);
        chk("midrst_value", 32'(value), 32'h0);
        chk("midrst_kv", 32'(key_valid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        mdl_q.delete();
        repeat (60) @(negedge clk);
        chk("midrst_no_pulse", 32'(kv_cnt - kv0), 32'd0);

        // Key '1' held from reset: samples at edges 4, 8, 12 -> pulse after edge 12.
        rst = 1'b1;
        keys = 16'h0001;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            @(posedge clk);
            #1;
            chk("accept_latency", 32'(key_valid), 32'(k == 12));
        end
        keys = '0;
        repeat (60) @(negedge clk);
        chk("first_value", 32'(value), 32'h0001);
        chk("first_code", 32'(key_code), 32'd0);
        mdl_apply(4'd0);
        settled = 1'b1;

        press(16'h0800, 4'd11, 50);
        chk("clear_value", 32'(value), 32'h0);

        // Digit entry 1,2,3,4 then 5 while full.
        press(16'h0001, 4'd0, 50);
        press(16'h0002, 4'd1, 50);
        press(16'h0004, 4'd2, 50);
        press(16'h0010, 4'd4, 50);
        chk("entry_value", 32'(value), 32'h1234);
        chk("entry_full", 32'(full), 32'd1);
        press(16'h0020, 4'd5, 50);
        chk("full_value", 32'(value), 32'h1234);

        press(16'h0080, 4'd7, 50);
        chk("bksp_value", 32'(value), 32'h0123);
        chk("bksp_cnt", 32'(digit_cnt), 32'd3);
        press(16'h0800, 4'd11, 50);
        chk("clr_value", 32'(value), 32'h0);
        chk("clr_cnt", 32'(digit_cnt), 32'd0);
        press(16'h0080, 4'd7, 50);
        chk("bksp_empty", 32'(value), 32'h0);

        // Bouncing key 5: alternate samples disagree, so nothing is accepted.
        settled = 1'b0;
        kv0 = kv_cnt;
        for (int i = 0; i < 25; i++) begin
            keys = 16'h0020;
            repeat (SCAN_DIV) @(negedge clk);
            keys = '0;
            repeat (SCAN_DIV) @(negedge clk);
        end
        repeat (40) @(negedge clk);
        chk("bounce_no_pulse", 32'(kv_cnt - kv0), 32'd0);
        press(16'h0020, 4'd5, 50);
        chk("after_bounce", 32'(value), 32'h0005);

        // Keys 8 and 9 together, held 200 cycles: lowest column wins, one pulse.
        press(16'h0600, 4'd9, 200);
        chk("two_key_value", 32'(value), 32'h0058);
        press(16'h4000, 4'd14, 50);
        chk("commit_value", 32'(value), 32'h0058);

        for (int i = 0; i < 25; i++) begin
            rc = 4'($urandom_range(0, 15));
            press(16'(1) << rc, rc, int'($urandom_range(45, 80)));
        end

        settled = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
